// File: rtl/gpu_axi_regs_if.sv
// AXI4-lite bundle for the GPU control/status register target.
// Slave side faces the register file, master side faces the host.
interface gpu_axi_regs_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/gpu_axi_regs.sv
// GPU control/status AXI4-lite register file.
// Frame config, start pulse, busy/done tracking and level irq.
module gpu_axi_regs #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  gpu_axi_regs_if.slave         bus,
  input  logic                  frame_end,
  output logic                  frame_start,
  output logic [31:0]           triangles_count,
  output logic [ADDR_WIDTH-1:0] base_addr_vertex,
  output logic [ADDR_WIDTH-1:0] base_addr_color,
  output logic                  irq
);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        aw_held_q, aw_held_d;
  logic [5:0]  aw_idx_q,  aw_idx_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] w_data_q,  w_data_d;
  logic [3:0]  w_strb_q,  w_strb_d;
  logic        bvalid_q,  bvalid_d;
  logic [1:0]  bresp_q,   bresp_d;
  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;
  logic        irq_en_q,  irq_en_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic [31:0] tri_q,     tri_d;
  logic [31:0] vtx_q,     vtx_d;
  logic [31:0] col_q,     col_d;
  logic        fstart_q,  fstart_d;
  logic        irq_q,     irq_d;

  logic        aw_fire, w_fire, ar_fire, wr_en;
  logic        start, done_clr;
  logic [5:0]  widx, ridx;
  logic [31:0] wd;
  logic [3:0]  ws;
  logic [31:0] rd_val;
  logic        rd_ok;
  logic        unused_ok;

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int n = 0; n < 4; n++)
      if (strb[n]) r[8*n +: 8] = new_v[8*n +: 8];
    return r;
  endfunction

  assign bus.awready = !aw_held_q && !bvalid_q;
  assign bus.wready  = !w_held_q && !bvalid_q;
  assign bus.arready = !rvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  assign frame_start      = fstart_q;
  assign irq              = irq_q;
  assign triangles_count  = tri_q;
  assign base_addr_vertex = vtx_q[ADDR_WIDTH-1:0];
  assign base_addr_color  = col_q[ADDR_WIDTH-1:0];

  assign unused_ok = ^{bus.awprot, bus.arprot,
                       bus.awaddr, bus.araddr};

  assign ridx = bus.araddr[7:2];

  // Read-side register mux; unmapped offsets read 0 with SLVERR
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    unique case (ridx)
      6'd0:    rd_val = {30'd0, irq_en_q, 1'b0};
      6'd1:    rd_val = {30'd0, done_q, busy_q};
      6'd2:    rd_val = tri_q;
      6'd3:    rd_val = vtx_q;
      6'd4:    rd_val = col_q;
      6'd5:    rd_val = VERSION;
      default: rd_ok  = 1'b0;
    endcase
  end

  // Next-state: channel holds, register writes, frame control, reads
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    irq_en_d  = irq_en_q;
    busy_d    = busy_q;
    tri_d     = tri_q;
    vtx_d     = vtx_q;
    col_d     = col_q;
    start     = 1'b0;
    done_clr  = 1'b0;

    aw_fire = bus.awvalid && bus.awready;
    w_fire  = bus.wvalid && bus.wready;
    ar_fire = bus.arvalid && bus.arready;
    wr_en   = (aw_held_q || aw_fire) && (w_held_q || w_fire);

    widx = aw_held_q ? aw_idx_q : bus.awaddr[7:2];
    wd   = w_held_q ? w_data_q : bus.wdata;
    ws   = w_held_q ? w_strb_q : bus.wstrb;

    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = bus.awaddr[7:2];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end
    if (bvalid_q && bus.bready)
      bvalid_d = 1'b0;

    if (wr_en) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (widx < 6'd6) ? OKAY : SLVERR;
      unique case (widx)
        6'd0: begin
          if (ws[0]) irq_en_d = wd[1];
          start = ws[0] && wd[0] && !busy_q;
        end
        6'd1:    done_clr = ws[0] && wd[1];
        6'd2:    tri_d = merge(tri_q, wd, ws);
        6'd3:    vtx_d = merge(vtx_q, wd, ws);
        6'd4:    col_d = merge(col_q, wd, ws);
        default: ;
      endcase
    end

    fstart_d = start;
    if (frame_end) busy_d = 1'b0;
    if (start)     busy_d = 1'b1;
    done_d = (done_q && !done_clr) || frame_end;
    irq_d  = done_q && irq_en_q;

    if (rvalid_q && bus.rready)
      rvalid_d = 1'b0;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_ok ? OKAY : SLVERR;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      irq_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tri_q     <= '0;
      vtx_q     <= '0;
      col_q     <= '0;
      fstart_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      irq_en_q  <= irq_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tri_q     <= tri_d;
      vtx_q     <= vtx_d;
      col_q     <= col_d;
      fstart_q  <= fstart_d;
      irq_q     <= irq_d;
    end
  end
endmodule

// File: tb/tb_gpu_axi_regs.sv
// Bench for gpu_axi_regs: directed plan steps, then random
// AXI traffic against a register-level reference model.
module tb_gpu_axi_regs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpu_axi_regs_if #(.ADDR_WIDTH(32)) bus();

  logic        frame_end;
  logic        frame_start;
  logic        irq;
  logic [31:0] tri_o, vtx_o, col_o;

  gpu_axi_regs #(
    .ADDR_WIDTH(32),
    .VERSION   (32'h0001_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .frame_end       (frame_end),
    .frame_start     (frame_start),
    .triangles_count (tri_o),
    .base_addr_vertex(vtx_o),
    .base_addr_color (col_o),
    .irq             (irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fs_count = 0;

  always @(negedge clk)
    if (frame_start === 1'b1) fs_count++;

  bit          m_irq_en, m_busy, m_done;
  logic [31:0] m_tri, m_vtx, m_col;
  int          m_starts = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_irq_en = 0; m_busy = 0; m_done = 0;
    m_tri = 0; m_vtx = 0; m_col = 0;
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3F);
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return (m_idx(a) < 6) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (m_idx(a))
      0: return m_irq_en ? 32'h2 : 32'h0;
      1: return (m_done ? 32'h2 : 32'h0) + (m_busy ? 32'h1 : 32'h0);
      2: return m_tri;
      3: return m_vtx;
      4: return m_col;
      5: return 32'h0001_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    logic [31:0] mask;
    mask = 0;
    for (int n = 0; n < 4; n++)
      if (s[n]) mask = mask | (32'hFF << (8 * n));
    case (m_idx(a))
      0: begin
        if (s[0]) m_irq_en = d[1];
        if (s[0] && d[0] && !m_busy) begin
          m_busy = 1;
          m_starts++;
        end
      end
      1: if (s[0] && d[1]) m_done = 0;
      2: m_tri = (m_tri & ~mask) | (d & mask);
      3: m_vtx = (m_vtx & ~mask) | (d & mask);
      4: m_col = (m_col & ~mask) | (d & mask);
      default: ;
    endcase
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_tri"}, tri_o, m_tri);
    chk({tag, "_vtx"}, vtx_o, m_vtx);
    chk({tag, "_col"}, col_o, m_col);
    chk({tag, "_irq"}, irq, m_done & m_irq_en);
    chk({tag, "_fs"}, fs_count, m_starts);
  endtask

  // skew>0: AW leads W by skew cycles; skew<0: W leads AW.
  // bw: cycle (from start) at which bready is raised.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int skew,
                           input int bw, input bit fe);
    int cyc, aw_at, w_at;
    bit aw_ok, w_ok, b_ok, b_seen, aw_hs, w_hs, b_hs;
    logic [1:0] resp;
    aw_at = skew < 0 ? -skew : 0;
    w_at  = skew > 0 ? skew : 0;
    cyc = 0; aw_ok = 0; w_ok = 0; b_ok = 0; b_seen = 0;
    resp = 2'bxx;
    while (!b_ok && cyc < 60) begin
      @(negedge clk);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = !aw_ok && cyc >= aw_at;
      bus.wvalid  = !w_ok && cyc >= w_at;
      bus.bready  = cyc >= bw;
      frame_end   = fe && cyc == 0;
      if (aw_ok && !w_ok) chk("awready_held", bus.awready, 0);
      if (w_ok && !aw_ok) chk("wready_held", bus.wready, 0);
      if (b_seen) chk("bvalid_hold", bus.bvalid, 1);
      if (bus.bvalid) b_seen = 1;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      b_hs  = bus.bvalid && bus.bready;
      if (b_hs) resp = bus.bresp;
      @(posedge clk);
      aw_ok = aw_ok | aw_hs;
      w_ok  = w_ok | w_hs;
      b_ok  = b_hs;
      cyc++;
    end
    #1;
    bus.bready = 0;
    frame_end  = 0;
    chk("wr_done", b_ok, 1);
    chk("bresp", resp, m_resp(a));
    m_write(a, d, s);
    if (fe) begin
      m_busy = 0;
      m_done = 1;
    end
    chk_outputs("wr");
  endtask

  task automatic axi_read(input logic [31:0] a, input int rw,
                          input string tag);
    int cyc;
    bit ar_ok, r_ok, r_seen, ar_hs, r_hs;
    logic [31:0] d0, exp_d;
    logic [1:0]  p0;
    exp_d = m_read(a);
    cyc = 0; ar_ok = 0; r_ok = 0; r_seen = 0;
    d0 = 'x; p0 = 'x;
    while (!r_ok && cyc < 60) begin
      @(negedge clk);
      bus.araddr  = a;
      bus.arvalid = !ar_ok;
      bus.rready  = cyc >= rw;
      if (r_seen) chk({tag, "_stable"}, bus.rdata, d0);
      if (bus.rvalid && !r_seen) begin
        r_seen = 1;
        d0 = bus.rdata;
        p0 = bus.rresp;
      end
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      @(posedge clk);
      ar_ok = ar_ok | ar_hs;
      r_ok  = r_hs;
      cyc++;
    end
    #1;
    bus.rready = 0;
    chk({tag, "_done"}, r_ok, 1);
    chk(tag, d0, exp_d);
    chk({tag, "_resp"}, p0, m_resp(a));
  endtask

  task automatic fe_pulse();
    @(negedge clk);
    frame_end = 1;
    @(negedge clk);
    frame_end = 0;
    m_busy = 0;
    m_done = 1;
    @(negedge clk);
    chk("fe_irq", irq, m_done & m_irq_en);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    if ($urandom_range(0, 3) == 0) idx = $urandom_range(6, 63);
    else idx = $urandom_range(0, 5);
    return ($urandom & 32'hFFFF_FF00) | (idx << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1;
    frame_end = 0;
    bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_awready", bus.awready, 1);
    chk("rst_wready", bus.wready, 1);
    chk("rst_arready", bus.arready, 1);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_fstart", frame_start, 0);
    chk_outputs("rst");
    rst = 0;

    axi_read(32'h14, 0, "rd_version");
    axi_read(32'h04, 0, "rd_status0");

    axi_write(32'h08, 32'h0000_0123, 4'b0011, 0, 0, 0);
    axi_write(32'h08, 32'hAABB_CCDD, 4'b1000, 0, 0, 0);
    chk("tri_strb", tri_o, 32'hAA00_0123);
    axi_read(32'h08, 1, "rd_tri");

    axi_write(32'h0C, 32'h1234_5678, 4'hF, 3, 8, 0);
    chk("vtx_skew", vtx_o, 32'h1234_5678);
    axi_write(32'h10, 32'h0BAD_F00D, 4'hF, -2, 2, 0);
    axi_read(32'h10, 2, "rd_col");

    axi_write(32'h00, 32'h3, 4'hF, 0, 0, 0);
    chk("start_pulse", fs_count, 1);
    axi_read(32'h04, 0, "rd_busy");
    axi_write(32'h00, 32'h3, 4'hF, 0, 0, 0);
    chk("start_ignored", fs_count, 1);
    fe_pulse();
    chk("irq_set", irq, 1);
    axi_read(32'h04, 0, "rd_done");
    axi_write(32'h04, 32'h2, 4'hF, 0, 0, 0);
    chk("irq_clr", irq, 0);

    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0, "rd_unmapped");
    for (int k = 0; k < 6; k++)
      axi_read(32'(k * 4), 0, "rd_all");

    fe_pulse();
    axi_write(32'h04, 32'h2, 4'hF, 0, 0, 1);
    axi_read(32'h04, 0, "rd_w1c_race");

    for (int i = 0; i < 60; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = rand_addr();
      if (op < 5)
        axi_write(a, $urandom, 4'($urandom),
                  int'($urandom_range(0, 4)) - 2,
                  $urandom_range(0, 3), 0);
      else if (op < 9)
        axi_read(a, $urandom_range(0, 3), "rd_rand");
      else
        fe_pulse();
    end

    @(negedge clk);
    bus.awaddr  = 32'h10;
    bus.wdata   = 32'hDEAD_BEEF;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1;
    bus.wvalid  = 1;
    bus.bready  = 0;
    @(negedge clk);
    bus.awvalid = 0;
    bus.wvalid  = 0;
    chk("pend_bvalid", bus.bvalid, 1);
    chk("pend_col", col_o, 32'hDEAD_BEEF);
    rst = 1;
    @(negedge clk);
    m_reset();
    chk("rst2_bvalid", bus.bvalid, 0);
    chk("rst2_awready", bus.awready, 1);
    chk("rst2_wready", bus.wready, 1);
    chk("rst2_fstart", frame_start, 0);
    chk("rst2_tri", tri_o, 0);
    chk("rst2_vtx", vtx_o, 0);
    chk("rst2_col", col_o, 0);
    chk("rst2_irq", irq, 0);
    rst = 0;
    for (int k = 0; k < 6; k++)
      axi_read(32'(k * 4), 0, "rd_rst2");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
